// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI slave and the SPI master.
// Holds the two-state frame FSM encoding and the SPI mode encoding {CPOL,CPHA}.
package spi_pkg;

   // Frame FSM state constants (legacy-compatible plain vectors)
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   // Enumerated view of the same encoding for tools and debug displays
   typedef enum logic [0:0] {
      STATE_IDLE   = 1'b0,
      STATE_ACTIVE = 1'b1
   } spi_state_e;

   // SPI mode encoding: bit 1 is CPOL, bit 0 is CPHA
   typedef enum logic [1:0] {
      SPI_MODE_0 = 2'b00,
      SPI_MODE_1 = 2'b01,
      SPI_MODE_2 = 2'b10,
      SPI_MODE_3 = 2'b11
   } spi_mode_e;

   function automatic logic mode_cpol(input logic [1:0] mode);
      return mode[1];
   endfunction

   function automatic logic mode_cpha(input logic [1:0] mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: brings one asynchronous SPI pin into the i_clock domain.
// Two synchronizer flops followed by one edge-detect flop; the level and
// edge pulses are combinational from the last two stages so the consuming
// logic registers the effect exactly three i_clock cycles after the pin moves.
module spi_sync_edge #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [2:0] pipe_q;
   logic [2:0] pipe_d;

   // Next pipeline contents: shift the raw pin in at the bottom
   always_comb begin
      pipe_d = {pipe_q[1:0], i_async};
   end

   // Synchronizer and edge-detect stages, reset to the pin's idle level
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         pipe_q <= {3{RESET_VALUE}};
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign o_level = pipe_q[1];
   assign o_rise  = pipe_q[1] & ~pipe_q[2];
   assign o_fall  = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave with a one-word transmit holding register.
// Supports all four CPOL/CPHA modes; the SPI pins are oversampled by i_clock.
// Build option: define SPI_SLAVE_LSB_FIRST_EN to shift words LSB-first on
// both MISO and MOSI; otherwise words are shifted MSB-first.
//
// Transmit handshake: a word moves from i_tx_data into the holding register
// on any i_clock edge where i_tx_valid and o_tx_ready are both high.
// o_tx_ready is high exactly when the holding register is empty; i_tx_data
// need only be stable in the cycle of the transfer.
module spi_slave
   import spi_pkg::*;
#(
   parameter int SPI_DATA_WIDTH = 8
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_clock_polarity,
   input  logic                      i_clock_phase,
   input  logic [SPI_DATA_WIDTH-1:0] i_tx_data,
   input  logic                      i_tx_valid,
   output logic                      o_tx_ready,
   output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
   output logic                      o_rx_valid,
   output logic                      o_busy,
   output logic                      o_frame_error,
   input  logic                      i_spi_cs_n,
   input  logic                      i_spi_clock,
   input  logic                      i_spi_mosi,
   output logic                      o_spi_miso,
   output logic                      o_spi_miso_oe,
   output logic [0:0]                o_dbg_state
);

   localparam int W     = SPI_DATA_WIDTH;
   localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   // Bit ordering helpers; the only place the shift direction is decided
   function automatic logic first_bit(input logic [W-1:0] word);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return word[0];
`else
      return word[W-1];
`endif
   endfunction

   function automatic logic [W-1:0] shift_out(input logic [W-1:0] word);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return word >> 1;
`else
      return word << 1;
`endif
   endfunction

   function automatic logic [W-1:0] shift_in(input logic [W-1:0] word, input logic din);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return {din, word[W-1:1]};
`else
      return {word[W-2:0], din};
`endif
   endfunction

   // Synchronized SPI pins
   logic cs_level, cs_rise, cs_fall;
   logic sclk_level, sclk_rise, sclk_fall;
   logic mosi_level, mosi_rise, mosi_fall;

   spi_sync_edge #(.RESET_VALUE(1'b1)) u_sync_cs (
      .i_clock(i_clock), .i_reset(i_reset), .i_async(i_spi_cs_n),
      .o_level(cs_level), .o_rise(cs_rise), .o_fall(cs_fall)
   );

   spi_sync_edge #(.RESET_VALUE(1'b0)) u_sync_sclk (
      .i_clock(i_clock), .i_reset(i_reset), .i_async(i_spi_clock),
      .o_level(sclk_level), .o_rise(sclk_rise), .o_fall(sclk_fall)
   );

   spi_sync_edge #(.RESET_VALUE(1'b0)) u_sync_mosi (
      .i_clock(i_clock), .i_reset(i_reset), .i_async(i_spi_mosi),
      .o_level(mosi_level), .o_rise(mosi_rise), .o_fall(mosi_fall)
   );

   // Only the edges of CS/SCLK and the level of MOSI carry meaning here
   logic unused_sync;
   assign unused_sync = &{1'b0, cs_level, sclk_level, mosi_rise, mosi_fall};

   // State
   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [W-1:0]     rx_shift_q, rx_shift_d;
   logic [W-1:0]     tx_shift_q, tx_shift_d;
   logic             miso_q, miso_d;
   logic [W-1:0]     hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [W-1:0]     rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             reload_q, reload_d;   // a word boundary passed; next shift edge loads a new word

   // Decoded edges and helper terms
   logic         lead_edge, trail_edge, sample_edge, shift_edge;
   logic         consume, tx_load;
   logic [W-1:0] next_word, rx_word;
   logic [1:0]   mode;

   // Frame FSM, shift datapath and holding-register bookkeeping
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      miso_d      = miso_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      reload_d    = reload_q;
      consume     = 1'b0;
      rx_word     = '0;

      mode        = {i_clock_polarity, i_clock_phase};
      lead_edge   = mode_cpol(mode) ? sclk_fall : sclk_rise;
      trail_edge  = mode_cpol(mode) ? sclk_rise : sclk_fall;
      sample_edge = mode_cpha(mode) ? trail_edge : lead_edge;
      shift_edge  = mode_cpha(mode) ? lead_edge  : trail_edge;
      tx_load     = i_tx_valid & ~hold_full_q;
      next_word   = hold_full_q ? hold_q : '0;

      case (state_q)
         ST_IDLE: begin
            // SCLK activity while deselected is ignored
            if (cs_fall) begin
               state_d    = ST_ACTIVE;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
               reload_d   = 1'b0;
               consume    = 1'b1;
               if (!mode_cpha(mode)) begin
                  // CPHA=0: first bit must be on the wire before the first sampling edge
                  miso_d     = first_bit(next_word);
                  tx_shift_d = shift_out(next_word);
               end else begin
                  // CPHA=1: first bit goes out on the first leading edge
                  tx_shift_d = next_word;
               end
            end
         end
         ST_ACTIVE: begin
            if (cs_rise) begin
               state_d    = ST_IDLE;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
               reload_d   = 1'b0;
               if (bit_cnt_q != '0) begin
                  frame_err_d = 1'b1;
               end
            end else begin
               if (sample_edge) begin
                  rx_word    = shift_in(rx_shift_q, mosi_level);
                  rx_shift_d = rx_word;
                  if (bit_cnt_q == CNT_LAST) begin
                     bit_cnt_d  = '0;
                     rx_data_d  = rx_word;
                     rx_valid_d = 1'b1;
                     reload_d   = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
               if (shift_edge) begin
                  if (reload_q) begin
                     consume    = 1'b1;
                     reload_d   = 1'b0;
                     miso_d     = first_bit(next_word);
                     tx_shift_d = shift_out(next_word);
                  end else begin
                     miso_d     = first_bit(tx_shift_q);
                     tx_shift_d = shift_out(tx_shift_q);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Consumption empties the register first; a same-cycle load then refills it
      if (consume) begin
         hold_full_d = 1'b0;
      end
      if (tx_load) begin
         hold_d      = i_tx_data;
         hold_full_d = 1'b1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         miso_q      <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         reload_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         miso_q      <= miso_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         reload_q    <= reload_d;
      end
   end

   assign o_tx_ready    = ~hold_full_q;
   assign o_rx_data     = rx_data_q;
   assign o_rx_valid    = rx_valid_q;
   assign o_busy        = (state_q == ST_ACTIVE);
   assign o_frame_error = frame_err_q;
   assign o_spi_miso    = miso_q;
   assign o_spi_miso_oe = o_busy;
   assign o_dbg_state   = state_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SPI_DATA_WIDTH, 8: bits per word, legal range 2..32.
REQ-002 i_clock  input  1  system clock; SHALL run at least 8x the SPI clock frequency.
REQ-003 i_reset  input  1  reset, synchronous, active-high.
REQ-004 i_clock_polarity  input  1  CPOL; SHALL be held static while o_busy=1.
REQ-005 i_clock_phase  input  1  CPHA; SHALL be held static while o_busy=1.
REQ-006 i_tx_data  input  SPI_DATA_WIDTH  next word to send on MISO.
REQ-007 i_tx_valid  input  1  i_tx_data valid.
REQ-008 o_tx_ready  output  1  holding register empty; transfer occurs when i_tx_valid & o_tx_ready.
REQ-009 o_rx_data  output  SPI_DATA_WIDTH  last complete word received on MOSI.
REQ-010 o_rx_valid  output  1  one-cycle pulse when o_rx_data updates.
REQ-011 o_busy  output  1  frame in progress (synchronized CS low).
REQ-012 o_frame_error  output  1  one-cycle pulse when CS rises mid-word.
REQ-013 i_spi_cs_n, i_spi_clock, i_spi_mosi  input  1 each  asynchronous SPI pins.
REQ-014 o_spi_miso  output  1  serial data out; o_spi_miso_oe  output  1  drive enable, equals o_busy.

Function
REQ-015 Each SPI input SHALL pass a 2-flop synchronizer, plus one edge-detect flop; a pin edge is acted on exactly 3 i_clock cycles later.
REQ-016 Leading edge SHALL be rising when CPOL=0, falling when CPOL=1; trailing edge is the opposite.
REQ-017 CPHA=0: sample MOSI on leading edge, shift MISO on trailing edge; CPHA=1: shift MISO on leading edge, sample on trailing edge.
REQ-018 FSM states IDLE, ACTIVE; IDLE->ACTIVE on synchronized CS falling; ACTIVE->IDLE on synchronized CS rising.
REQ-019 On IDLE->ACTIVE the shift register SHALL load the holding register (or all-zeros if empty), empty the holding register, and for CPHA=0 drive its first bit on o_spi_miso in the same cycle.
REQ-020 For CPHA=1 the first bit SHALL be driven on the first leading edge; o_spi_miso SHALL hold its value between shift edges.
REQ-021 Bit counter SHALL count sampling edges 0..SPI_DATA_WIDTH-1 and wrap to 0.
REQ-022 On the SPI_DATA_WIDTH-th sampling edge, o_rx_data SHALL update and o_rx_valid pulse on the next cycle.
REQ-023 CS low across a word boundary: the first shift edge after the boundary SHALL reload from the holding register (zeros if empty) and empty it; back-to-back words supported.
REQ-024 Holding-register load and consumption in the same cycle: consumption wins, new word is stored afterwards; o_tx_ready falls the cycle after a load.
REQ-025 CS rising with bit counter nonzero: o_frame_error pulse, no o_rx_valid, partial word discarded, counter cleared.
REQ-026 SPI clock edges while CS high SHALL be ignored.

Reset
REQ-027 On i_reset: state IDLE, counter 0, shift registers 0, holding register empty, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_busy=0, o_frame_error=0, o_spi_miso=0, o_spi_miso_oe=0; synchronizer flops reset to CS=1, SCLK=0, MOSI=0.
REQ-028 Reset mid-frame SHALL abort without o_frame_error; a frame begins only on a CS falling edge seen after reset.

Configuration
REQ-029 With SPI_SLAVE_LSB_FIRST_EN defined, words SHALL be shifted LSB-first on both MISO and MOSI; without it, MSB-first.

Structure
REQ-030 Package spi_pkg SHALL hold the FSM state enum and the SPI mode encoding {CPOL,CPHA}, shared with spi_master.
REQ-031 Sub-module spi_sync_edge (2-flop synchronizer plus rising/falling pulse outputs) SHALL be instantiated per SPI input.

Verification
REQ-032 Mode 0, tx 0xA5 preloaded, master sends 0x3C: MISO bits 1,0,1,0,0,1,0,1; o_rx_data=0x3C, one o_rx_valid pulse.
REQ-033 Modes 1, 2, 3 each, tx 0x81, master sends 0x7E: master reads 0x81, o_rx_data=0x7E.
REQ-034 Mode 0, 2-word frame, tx 0x11 then 0x22 loaded during word 1: master reads 0x11,0x22; two o_rx_valid pulses.
REQ-035 Empty holding register at CS fall: MISO sends 0x00; rx still valid.
REQ-036 CS rises after 5 bits: o_frame_error one pulse, no o_rx_valid, next full frame received correctly.
REQ-037 i_reset asserted mid-word: all outputs at reset values next cycle, no o_frame_error; LSB-first build, tx 0x01: first MISO bit 1.
